// File: rtl/lcv_dot_acc_pkg.sv
// Shared types and constants for the saturating dot-product accumulator.
package lcv_dot_acc_pkg;

  typedef enum logic [1:0] {RUN, DRAIN, HOLD} state_t;

  localparam int PROD_W = 32;
  localparam int SUM_W  = 33;

  localparam logic signed [SUM_W-1:0] SAT_MAX = 33'sh0_FFFF_FFFF;
  localparam logic signed [SUM_W-1:0] SAT_MIN = 33'sh1_0000_0000;

endpackage

// File: rtl/lcv_sat_add33.sv
// Combinational saturating add of a 32-bit product into a 33-bit accumulator.
module lcv_sat_add33
  import lcv_dot_acc_pkg::*;
(
  input  logic signed [SUM_W-1:0]  acc,
  input  logic signed [PROD_W-1:0] prod,
  output logic signed [SUM_W-1:0]  sum,
  output logic                     clamp
);

  logic signed [SUM_W:0] wide;

  assign wide = {acc[SUM_W-1], acc} + {{2{prod[PROD_W-1]}}, prod};

  // The 34-bit result leaves the 33-bit range exactly when its top two bits differ.
  always_comb begin
    sum   = wide[SUM_W-1:0];
    clamp = 1'b0;
    if (wide[SUM_W] != wide[SUM_W-1]) begin
      clamp = 1'b1;
      sum   = wide[SUM_W] ? SAT_MIN : SAT_MAX;
    end
  end

endmodule

// File: rtl/lcv_dot_acc.sv
// Two-stage (multiply, accumulate) signed dot product per packet; result held until out_ready.
// Input stalls from the last beat until the result is handed off.
module lcv_dot_acc
  import lcv_dot_acc_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [15:0]      in_a,
  input  logic signed [15:0]      in_b,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [SUM_W-1:0] out_sum,
  output logic                    out_ovf,
  output logic [CNT_W-1:0]        out_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t                   state;
  logic                     xfer;
  logic signed [PROD_W-1:0] prod_n;
  logic                     p_vld;
  logic                     p_last;
  logic signed [PROD_W-1:0] p_prod;
  logic signed [SUM_W-1:0]  acc;
  logic                     ovf;
  logic [CNT_W-1:0]         cnt;
  logic signed [SUM_W-1:0]  sum_n;
  logic                     clamp_n;

  assign xfer   = in_valid && in_ready;
  assign prod_n = 32'(in_a) * 32'(in_b);

  lcv_sat_add33 u_sat (
    .acc   (acc),
    .prod  (p_prod),
    .sum   (sum_n),
    .clamp (clamp_n)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      in_ready  <= 1'b1;
      p_vld     <= 1'b0;
      p_last    <= 1'b0;
      p_prod    <= '0;
      acc       <= '0;
      ovf       <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
      out_cnt   <= '0;
    end else begin
      p_vld <= xfer;
      if (xfer) begin
        p_prod <= prod_n;
        p_last <= in_last;
        if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
      end
      if (p_vld) begin
        acc <= sum_n;
        ovf <= ovf | clamp_n;
      end

      case (state)
        RUN: begin
          if (xfer && in_last) begin
            state    <= DRAIN;
            in_ready <= 1'b0;
          end
        end
        DRAIN: begin
          // Counter already includes the last beat: it was bumped on the transfer edge.
          if (p_vld && p_last) begin
            state     <= HOLD;
            out_valid <= 1'b1;
            out_sum   <= sum_n;
            out_ovf   <= ovf | clamp_n;
            out_cnt   <= cnt;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= RUN;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            acc       <= '0;
            ovf       <= 1'b0;
            cnt       <= '0;
          end
        end
        default: begin
          state    <= RUN;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcv_dot_acc.sv
// Randomized bench for lcv_dot_acc against a per-packet arithmetic reference model.
module tb_lcv_dot_acc;

  localparam int  CNT_W   = 4;
  localparam longint S_MAX = 64'sd4294967295;
  localparam longint S_MIN = -64'sd4294967296;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_a;
  logic signed [15:0] in_b;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic signed [32:0] out_sum;
  logic               out_ovf;
  logic [CNT_W-1:0]   out_cnt;

  int checks = 0;
  int errors = 0;
  int qa[$];
  int qb[$];

  lcv_dot_acc #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .out_cnt   (out_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // In-valid low with garbage on the data lines, which must be ignored.
  task automatic bubble();
    in_valid = 1'b0;
    in_a     = 16'($urandom);
    in_b     = 16'($urandom);
    in_last  = 1'($urandom);
    tick();
  endtask

  function automatic int rand_op();
    case ($urandom_range(0, 3))
      0:       return -32768;
      1:       return 32767;
      default: return int'($signed(16'($urandom)));
    endcase
  endfunction

  // Sends qa/qb as one packet, checks latency and result, holds for `hold` cycles, then hands off.
  task automatic run_packet(input string name, input int gaps, input int hold);
    longint acc = 0;
    longint ecnt;
    bit     eovf = 1'b0;
    foreach (qa[i]) begin
      acc += longint'(qa[i]) * longint'(qb[i]);
      if (acc > S_MAX) begin acc = S_MAX; eovf = 1'b1; end
      if (acc < S_MIN) begin acc = S_MIN; eovf = 1'b1; end
    end
    ecnt = (qa.size() > (2**CNT_W - 1)) ? (2**CNT_W - 1) : qa.size();
    out_ready = 1'b0;

    foreach (qa[i]) begin
      repeat ($urandom_range(0, gaps)) bubble();
      chk({name, "_in_ready"}, in_ready, 1);
      in_valid = 1'b1;
      in_a     = 16'(qa[i]);
      in_b     = 16'(qb[i]);
      in_last  = (i == qa.size() - 1);
      tick();
    end
    in_valid = 1'b0;
    chk({name, "_valid_edge1"}, out_valid, 0);
    chk({name, "_ready_drain"}, in_ready, 0);
    tick();
    chk({name, "_valid_edge2"}, out_valid, 1);
    chk({name, "_sum"}, out_sum, acc);
    chk({name, "_cnt"}, out_cnt, ecnt);
    chk({name, "_ovf"}, out_ovf, eovf);

    repeat (hold) begin
      in_valid = 1'($urandom);
      in_a     = 16'($urandom);
      in_b     = 16'($urandom);
      in_last  = 1'($urandom);
      tick();
      chk({name, "_hold_valid"}, out_valid, 1);
      chk({name, "_hold_sum"}, out_sum, acc);
      chk({name, "_hold_cnt"}, out_cnt, ecnt);
      chk({name, "_hold_ovf"}, out_ovf, eovf);
      chk({name, "_hold_ready"}, in_ready, 0);
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({name, "_done_valid"}, out_valid, 0);
    chk({name, "_done_ready"}, in_ready, 1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_sum", out_sum, 0);
    chk("rst_cnt", out_cnt, 0);
    chk("rst_ovf", out_ovf, 0);
    rst = 1'b0;
    tick();
    chk("rst_ready", in_ready, 1);

    qa = '{2, -4, 7};       qb = '{3, 5, -1};            run_packet("three", 0, 0);
    qa = '{-32768};         qb = '{-32768};              run_packet("single", 0, 0);
    qa = '{-32768, -32768, -32768, -32768, -32768};
    qb = '{-32768, -32768, -32768, -32768, -32768};      run_packet("sat5", 0, 0);
    qa = '{7, 7};           qb = '{9, 9};                run_packet("bp", 0, 10);
    qa = '{1};              qb = '{1};                   run_packet("after_bp", 0, 0);

    // Two beats of a packet, then reset: nothing of that packet may surface.
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_a = 16'sd100; in_b = 16'sd100; in_last = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_sum", out_sum, 0);
    chk("midrst_cnt", out_cnt, 0);
    chk("midrst_ready", in_ready, 1);
    qa = '{3};              qb = '{3};                   run_packet("post_rst", 0, 0);

    qa = '{1, 3};           qb = '{2, 4};
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 16'sd1; in_b = 16'sd2; in_last = 1'b0;
    tick();
    bubble();
    bubble();
    qa = '{3};              qb = '{4};
    // Accumulator already holds 2 from the first beat; model the rest as a packet tail.
    in_valid = 1'b1; in_a = 16'sd3; in_b = 16'sd4; in_last = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("gap_valid", out_valid, 1);
    chk("gap_sum", out_sum, 14);
    chk("gap_cnt", out_cnt, 2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("gap_done_ready", in_ready, 1);

    qa.delete(); qb.delete();
    for (int i = 0; i < 20; i++) begin qa.push_back(rand_op()); qb.push_back(rand_op()); end
    run_packet("cnt_sat", 2, 1);

    for (int p = 0; p < 30; p++) begin
      int n;
      n = $urandom_range(1, 10);
      qa.delete(); qb.delete();
      for (int i = 0; i < n; i++) begin qa.push_back(rand_op()); qb.push_back(rand_op()); end
      run_packet("rnd", 3, $urandom_range(0, 4));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcv_dot_acc.md
LCV_DOT_ACC -- requirements
Module: lcv_dot_acc

Interface
REQ-001 The block SHALL use reset rst, synchronous, active-high, and clock clk.
REQ-002 Parameter CNT_W, default 8, SHALL set the width of the beat counter output.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 in_valid  in  1  operand beat valid.
REQ-006 in_ready  out  1  block accepts a beat; a beat transfers on an edge where in_valid and in_ready are both 1.
REQ-007 in_a  in  16  signed multiplicand.
REQ-008 in_b  in  16  signed multiplier.
REQ-009 in_last  in  1  marks the final beat of a packet.
REQ-010 out_valid  out  1  result valid.
REQ-011 out_ready  in  1  downstream accepts the result; the result transfers when out_valid and out_ready are both 1.
REQ-012 out_sum  out  33  signed, saturated dot product of the packet.
REQ-013 out_ovf  out  1  saturation occurred at least once during the packet.
REQ-014 out_cnt  out  CNT_W  beats in the packet, saturating at 2^CNT_W-1.

Function
REQ-015 Stage P SHALL register prod = in_a*in_b as a 32-bit signed value on the edge after the beat transfers, along with a valid bit and a last bit.
REQ-016 Stage A SHALL update acc = sat33(acc + prod) on the edge after stage P holds a valid product.
- sat33 clamps to [-2^32, 2^32-1].
- The adder is at least 34 bits wide.
REQ-017 Any clamp in REQ-016 SHALL set the sticky ovf bit for the current packet.
REQ-018 The FSM SHALL have three states: RUN, DRAIN, HOLD; the reset state is RUN.
REQ-019 in_ready SHALL be 1 only in RUN.
REQ-020 RUN->DRAIN SHALL occur on the edge that transfers a beat with in_last=1.
REQ-021 DRAIN->HOLD SHALL occur on the edge where stage A absorbs the last product.
- On that same edge, out_sum, out_ovf, out_cnt and out_valid=1 are registered.
- out_valid therefore rises on the 2nd edge after the last beat transfers.
REQ-022 In HOLD, out_valid, out_sum, out_ovf and out_cnt SHALL stay stable until out_ready=1.
REQ-023 On the HOLD handoff edge, the block SHALL:
- clear out_valid, acc, ovf and the counter;
- move to RUN, so in_ready=1 in the following cycle.
REQ-024 in_valid bubbles in RUN SHALL NOT change acc or the counter.
REQ-025 A bubble after the last beat SHALL NOT happen: the pipeline always drains in exactly 2 edges.
REQ-026 The beat counter SHALL increment per transferred beat and hold at 2^CNT_W-1.
REQ-027 A single-beat packet (in_last on the first beat) SHALL produce sum = prod, with cnt = 1.
REQ-028 in_a, in_b and in_last SHALL be ignored when no transfer occurs.

Reset
REQ-029 While rst=1, these SHALL be 0 on the next edge: out_valid, out_sum, out_ovf, out_cnt, acc, ovf, counter and stage P valid.
REQ-030 While rst=1, the FSM SHALL go to RUN, making in_ready=1 in the cycle after rst deasserts.
REQ-031 Reset mid-packet or in HOLD SHALL discard all partial state; no result is emitted for that packet.
REQ-032 rst SHALL take priority over any simultaneous transfer.

Structure
REQ-033 Package lcv_dot_acc_pkg SHALL hold the following:
- the state enum (RUN, DRAIN, HOLD);
- constants PROD_W=32, SUM_W=33, SAT_MAX=2^32-1, SAT_MIN=-2^32.
REQ-034 The saturating accumulate SHALL be implemented in sub-module lcv_sat_add33.
- Inputs: a 33-bit acc and a 32-bit prod.
- Outputs: a 33-bit clamped sum and a clamp flag.
- It is purely combinational.

Verification
REQ-035 Beats (2,3),(-4,5),(7,-1,last) -> out_sum=-21, out_cnt=3, out_ovf=0, out_valid high 2 edges after the last transfer.
REQ-036 Single beat (-32768,-32768,last) -> out_sum=1073741824, out_cnt=1, out_ovf=0.
REQ-037 Five beats (-32768,-32768), last on the 5th -> out_sum=4294967295, out_ovf=1, out_cnt=5.
REQ-038 Backpressure case:
- Stimulus: out_ready=0 for 10 cycles after out_valid rises.
- Required: outputs stable and in_ready=0 throughout.
- Then out_ready=1 for 1 cycle -> out_valid=0 and in_ready=1 next cycle; the next packet (1,1,last) gives out_sum=1.
REQ-039 Reset mid-packet case:
- Stimulus: two beats (100,100), then rst for 1 cycle, then (3,3,last).
- Required: out_sum=9, out_cnt=1.
REQ-040 Beats (1,2),bubble,bubble,(3,4,last) with in_valid gaps -> out_sum=14, out_cnt=2.
